ror_multicore_scheduler: RTL
============================

Name: ror_multicore_scheduler

Overview:
Parametrised successor to the single-core ROR (radius outlier removal) controller for lidar denoising. Runs CORE_NUMBER target points in parallel against DISTANCE_MODULES feeder points per cycle. Computes squared 3D distance in-block and counts neighbours, with early exit once every active target has enough neighbours. Pushes outlier indices into an internal first-word-fall-through (FWFT) FIFO that has backpressure.

Parameters:
N, 16, signed coordinate width
CORE_NUMBER, 2, targets evaluated in parallel
DISTANCE_MODULES, 2, feeder points per cycle (M)
IDX_W, 16, point index width
CNT_W, 8, neighbour counter width
FIFO_DEPTH, 64, outlier FIFO depth (power of 2)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low
start  in  1  one-cycle pulse; latches configuration and begins a run
point_cloud_size  in  IDX_W  number of points
radius_sq  in  2N+4  squared radius threshold, unsigned
min_neighbors  in  CNT_W  neighbours required to keep a point
point_pos  out  IDX_W  base index of the target group
cache_x/cache_y/cache_z  in  N*CORE_NUMBER  target coordinates for point_pos+c (c=0 in LSBs), valid 1 cycle after point_pos
feeder_pos  out  IDX_W  base index of the feeder group
cache_feeder_x/y/z  in  N*DISTANCE_MODULES  feeder coordinates for feeder_pos+m, valid 1 cycle after feeder_pos
read_fifo  in  1  pop the FIFO head
outlier_pos_fifo  out  IDX_W  FIFO head, valid while !empty
empty  out  1  FIFO empty
full  out  1  FIFO full
busy  out  1  run in progress
done  out  1  run complete; FIFO may still hold data
outlier_count  out  IDX_W  outliers pushed this run

Behaviour:
- Reset (reset=0 at a clock edge):
  - State goes to IDLE; FIFO is cleared.
  - point_pos=0, feeder_pos=0, busy=0, done=0, empty=1, full=0, outlier_pos_fifo=0, outlier_count=0.
  - Reset mid-run aborts the run; nothing persists.
- IDLE/DONE:
  - start=1 latches size, radius_sq and min_neighbors.
  - Clears FIFO and outlier_count, sets point_pos=0, busy=1, done=0, then goes to LOAD.
  - If size=0: goes to DONE instead (done=1, busy=0 next cycle).
  - start is ignored while busy.
- LOAD (1 cycle):
  - Registers target coords and valid_t[c] = (point_pos+c < size).
  - Clears neighbour counters; feeder_pos=0; goes to SWEEP.
- SWEEP:
  - feeder_pos += M each cycle while feeder_pos < size.
  - Data returns 1 cycle later, so a one-stage valid pipeline tracks the feeder index.
  - Pair (c,m) is counted when all hold: feeder valid, feeder index < size, feeder index != target index, valid_t[c].
  - Distance: dx = sign-extended to N+1 bits, dx²+dy²+dz² computed in 2N+4 bits with no overflow. Hit when d² <= radius_sq.
  - Counter per core adds its hits and saturates at min_neighbors.
  - Exit to DECIDE on either condition:
    - every valid target has count >= min_neighbors (early exit; in-flight data is discarded), or
    - the last feeder group's data has been processed.
- DECIDE:
  - Pushes point_pos+c for each valid core with count < min_neighbors.
  - One push per cycle, ascending c; outlier_count increments per push.
  - If full=1, holds with no drop. Push is blocked when full even if read_fifo is asserted the same cycle.
  - After the last push, point_pos += CORE_NUMBER.
  - Goes to LOAD if the new point_pos < size, else DONE (done=1, busy=0).
- FIFO:
  - FWFT; pop on read_fifo & !empty; read_fifo while empty is ignored.
  - Simultaneous push and pop when not full keeps occupancy unchanged.
  - Readable in every state.
- min_neighbors=0: every sweep exits early on its first cycle; no outliers are produced.
- No feeder wrap-around: indices >= size are masked, not wrapped.

Test Plan:
1. CORE=2, M=2, size=4, points (0,0,0),(1,0,0),(0,1,0),(100,100,100), radius_sq=4, min=1 -> FIFO yields only index 3; outlier_count=1; done=1.
2. 64 identical points, min=2 -> every SWEEP lasts <=3 cycles; run ends with empty=1, outlier_count=0.
3. FIFO_DEPTH=4, 10 points spaced 1000 apart, min=1, read_fifo=0 -> full=1 and DECIDE stalls at count 4; then enable reads -> indices 0..9 in order, none lost.
4. size=5, CORE=2 -> last group evaluates only index 4; index 5 is never pushed; feeder_pos never issues >= 6.
5. Extreme coordinates: x=0x8000 vs 0x7FFF (others 0), radius_sq=65535² -> neighbour counted (d²=65535², no overflow); radius_sq=65535²-1 -> not counted.
6. reset=0 mid-SWEEP -> next cycle all outputs at reset values with empty=1; restart with test 1 data reproduces the test 1 result.

Source files
------------

// File: rtl/ror_multicore_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : ror_multicore_scheduler
//  Purpose  : Multi-core radius-outlier-removal controller. Evaluates
//             CORE_NUMBER targets against DISTANCE_MODULES feeder points per
//             cycle and queues outlier indices in an internal FWFT FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module ror_multicore_scheduler #(
    parameter int N                = 16,
    parameter int CORE_NUMBER      = 2,
    parameter int DISTANCE_MODULES = 2,
    parameter int IDX_W            = 16,
    parameter int CNT_W            = 8,
    parameter int FIFO_DEPTH       = 64
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [IDX_W-1:0]              point_cloud_size,
    input  logic [2*N+3:0]                radius_sq,
    input  logic [CNT_W-1:0]              min_neighbors,
    output logic [IDX_W-1:0]              point_pos,
    input  logic [N*CORE_NUMBER-1:0]      cache_x,
    input  logic [N*CORE_NUMBER-1:0]      cache_y,
    input  logic [N*CORE_NUMBER-1:0]      cache_z,
    output logic [IDX_W-1:0]              feeder_pos,
    input  logic [N*DISTANCE_MODULES-1:0] cache_feeder_x,
    input  logic [N*DISTANCE_MODULES-1:0] cache_feeder_y,
    input  logic [N*DISTANCE_MODULES-1:0] cache_feeder_z,
    input  logic                          read_fifo,
    output logic [IDX_W-1:0]              outlier_pos_fifo,
    output logic                          empty,
    output logic                          full,
    output logic                          busy,
    output logic                          done,
    output logic [IDX_W-1:0]              outlier_count
);

    localparam int c_XW     = IDX_W + 1;
    localparam int c_DW     = 2*N + 4;
    localparam int c_PW     = 2*N + 2;
    localparam int c_HIT_W  = $clog2(DISTANCE_MODULES + 1);
    localparam int c_SUM_W  = CNT_W + c_HIT_W;
    localparam int c_CORE_W = (CORE_NUMBER > 1) ? $clog2(CORE_NUMBER) : 1;
    localparam int c_AW     = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SWEEP  = 3'd2,
        S_DECIDE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                  r_state;
    logic [IDX_W-1:0]        r_point_pos;
    logic [IDX_W-1:0]        r_feeder_pos;
    logic [IDX_W-1:0]        r_size;
    logic [c_DW-1:0]         r_radius;
    logic [CNT_W-1:0]        r_min;
    logic [CORE_NUMBER-1:0]  r_valid_t;
    logic [CORE_NUMBER-1:0]  r_pending;
    logic signed [N-1:0]     r_tx [CORE_NUMBER];
    logic signed [N-1:0]     r_ty [CORE_NUMBER];
    logic signed [N-1:0]     r_tz [CORE_NUMBER];
    logic [CNT_W-1:0]        r_cnt [CORE_NUMBER];
    logic                    r_first;
    logic                    r_issue_done;
    logic                    r_fv;
    logic                    r_flast;
    logic [IDX_W-1:0]        r_fidx;
    logic                    r_busy;
    logic                    r_done;
    logic [IDX_W-1:0]        r_outlier_count;
    logic [c_AW:0]           r_wptr;
    logic [c_AW:0]           r_rptr;
    logic [IDX_W-1:0]        r_mem [FIFO_DEPTH];

    logic [CNT_W-1:0]        w_cnt_next [CORE_NUMBER];
    logic [CORE_NUMBER-1:0]  w_core_ok;
    logic [CORE_NUMBER-1:0]  w_outlier;
    logic [c_XW-1:0]         w_feed_next;
    logic                    w_feed_more;
    logic [c_XW-1:0]         w_pp_next;
    logic                    w_pp_more;
    logic                    w_sel_found;
    logic [c_CORE_W-1:0]     w_sel_idx;
    logic                    w_start_ok;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_push;
    logic                    w_pop;
    logic [IDX_W-1:0]        w_push_data;

    assign w_feed_next = {1'b0, r_feeder_pos} + c_XW'(DISTANCE_MODULES);
    assign w_feed_more = w_feed_next < {1'b0, r_size};
    assign w_pp_next   = {1'b0, r_point_pos} + c_XW'(CORE_NUMBER);
    assign w_pp_more   = w_pp_next < {1'b0, r_size};
    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Distance evaluation and per-core neighbour accumulation
    for (genvar gc = 0; gc < CORE_NUMBER; gc++) begin : g_core
        logic [DISTANCE_MODULES-1:0] w_hit;
        logic [c_HIT_W-1:0]          w_hitcnt;
        logic [c_SUM_W-1:0]          w_sum;
        logic [c_XW-1:0]             w_tidx;

        assign w_tidx = {1'b0, r_point_pos} + c_XW'(gc);

        for (genvar gm = 0; gm < DISTANCE_MODULES; gm++) begin : g_mod
            logic signed [N-1:0]    w_fx, w_fy, w_fz;
            logic signed [N:0]      w_dx, w_dy, w_dz;
            logic signed [c_PW-1:0] w_ex, w_ey, w_ez;
            logic signed [c_PW-1:0] w_sqx, w_sqy, w_sqz;
            logic [c_DW-1:0]        w_d2;
            logic [c_XW-1:0]        w_fidx;

            assign w_fx   = cache_feeder_x[gm*N +: N];
            assign w_fy   = cache_feeder_y[gm*N +: N];
            assign w_fz   = cache_feeder_z[gm*N +: N];
            // One extra bit keeps the difference of two extreme values exact
            assign w_dx   = (N+1)'(r_tx[gc]) - (N+1)'(w_fx);
            assign w_dy   = (N+1)'(r_ty[gc]) - (N+1)'(w_fy);
            assign w_dz   = (N+1)'(r_tz[gc]) - (N+1)'(w_fz);
            assign w_ex   = c_PW'(w_dx);
            assign w_ey   = c_PW'(w_dy);
            assign w_ez   = c_PW'(w_dz);
            assign w_sqx  = w_ex * w_ex;
            assign w_sqy  = w_ey * w_ey;
            assign w_sqz  = w_ez * w_ez;
            assign w_d2   = c_DW'($unsigned(w_sqx)) + c_DW'($unsigned(w_sqy))
                          + c_DW'($unsigned(w_sqz));
            assign w_fidx = {1'b0, r_fidx} + c_XW'(gm);
            assign w_hit[gm] = r_fv && (w_fidx < {1'b0, r_size}) && (w_fidx != w_tidx)
                             && r_valid_t[gc] && (w_d2 <= r_radius);
        end

        // Population count of this core's hits across all feeder lanes
        always_comb begin
            w_hitcnt = '0;
            for (int m = 0; m < DISTANCE_MODULES; m++) begin
                w_hitcnt = w_hitcnt + c_HIT_W'(w_hit[m]);
            end
        end

        assign w_sum          = c_SUM_W'(r_cnt[gc]) + c_SUM_W'(w_hitcnt);
        assign w_cnt_next[gc] = (w_sum >= c_SUM_W'(r_min)) ? r_min : w_sum[CNT_W-1:0];
        assign w_core_ok[gc]  = !r_valid_t[gc] || (w_cnt_next[gc] >= r_min);
        assign w_outlier[gc]  = r_valid_t[gc] && (w_cnt_next[gc] < r_min);
    end

    // Lowest-numbered core still waiting to push its outlier index
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int c = CORE_NUMBER - 1; c >= 0; c--) begin
            if (r_pending[c]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = c_CORE_W'(c);
            end
        end
    end

    assign w_empty     = (r_wptr == r_rptr);
    assign w_full      = (r_wptr[c_AW] != r_rptr[c_AW]) && (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign w_push      = (r_state == S_DECIDE) && w_sel_found && !w_full;
    assign w_pop       = read_fifo && !w_empty;
    assign w_push_data = r_point_pos + IDX_W'(w_sel_idx);

    // Run control: configuration latch, target load, feeder sweep, outlier decision
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_point_pos     <= '0;
            r_feeder_pos    <= '0;
            r_size          <= '0;
            r_radius        <= '0;
            r_min           <= '0;
            r_valid_t       <= '0;
            r_pending       <= '0;
            r_first         <= 1'b0;
            r_issue_done    <= 1'b0;
            r_fv            <= 1'b0;
            r_flast         <= 1'b0;
            r_fidx          <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_outlier_count <= '0;
            for (int c = 0; c < CORE_NUMBER; c++) begin
                r_tx[c]  <= '0;
                r_ty[c]  <= '0;
                r_tz[c]  <= '0;
                r_cnt[c] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_size          <= point_cloud_size;
                        r_radius        <= radius_sq;
                        r_min           <= min_neighbors;
                        r_outlier_count <= '0;
                        r_point_pos     <= '0;
                        r_feeder_pos    <= '0;
                        if (point_cloud_size == '0) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_LOAD;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end
                end
                S_LOAD: begin
                    for (int c = 0; c < CORE_NUMBER; c++) begin
                        r_valid_t[c] <= ({1'b0, r_point_pos} + c_XW'(c)) < {1'b0, r_size};
                        r_cnt[c]     <= '0;
                    end
                    r_feeder_pos <= '0;
                    r_first      <= 1'b1;
                    r_issue_done <= 1'b0;
                    r_fv         <= 1'b0;
                    r_flast      <= 1'b0;
                    r_state      <= S_SWEEP;
                end
                S_SWEEP: begin
                    r_first <= 1'b0;
                    // Target data for point_pos is readable one cycle after it
                    // changed, which is the first sweep cycle; the first feeder
                    // data arrives one cycle later, so nothing is lost.
                    if (r_first) begin
                        for (int c = 0; c < CORE_NUMBER; c++) begin
                            r_tx[c] <= cache_x[c*N +: N];
                            r_ty[c] <= cache_y[c*N +: N];
                            r_tz[c] <= cache_z[c*N +: N];
                        end
                    end
                    // feeder_pos stops at the last group instead of running past size
                    if (!r_issue_done) begin
                        r_fv    <= 1'b1;
                        r_fidx  <= r_feeder_pos;
                        r_flast <= !w_feed_more;
                        if (w_feed_more) begin
                            r_feeder_pos <= w_feed_next[IDX_W-1:0];
                        end else begin
                            r_issue_done <= 1'b1;
                        end
                    end else begin
                        r_fv    <= 1'b0;
                        r_flast <= 1'b0;
                    end
                    for (int c = 0; c < CORE_NUMBER; c++) begin
                        r_cnt[c] <= w_cnt_next[c];
                    end
                    if ((&w_core_ok) || (r_fv && r_flast)) begin
                        r_pending <= w_outlier;
                        r_fv      <= 1'b0;
                        r_state   <= S_DECIDE;
                    end
                end
                S_DECIDE: begin
                    if (w_sel_found) begin
                        if (!w_full) begin
                            r_pending[w_sel_idx] <= 1'b0;
                            r_outlier_count      <= r_outlier_count + 1'b1;
                        end
                    end else begin
                        r_point_pos <= w_pp_next[IDX_W-1:0];
                        if (w_pp_more) begin
                            r_state <= S_LOAD;
                        end else begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // FIFO pointers: cleared by reset and by an accepted start
    always_ff @(posedge clock) begin
        if (!reset || w_start_ok) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // FIFO storage write port
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wptr[c_AW-1:0]] <= w_push_data;
    end

    assign point_pos        = r_point_pos;
    assign feeder_pos       = r_feeder_pos;
    assign busy             = r_busy;
    assign done             = r_done;
    assign outlier_count    = r_outlier_count;
    assign empty            = w_empty;
    assign full             = w_full;
    assign outlier_pos_fifo = w_empty ? '0 : r_mem[r_rptr[c_AW-1:0]];

endmodule
`default_nettype wire
